// File: rtl/alarm_siren_ctrl.sv
// Alarm siren sequencer: entry delay, pulsed siren with timeout, hold-off and a
// saturating trip counter.
module alarm_siren_ctrl #(
  parameter int DELAY_CYC = 16,
  parameter int SIREN_CYC = 64,
  parameter int TONE_HALF = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alarm,
  input  logic       panic,
  input  logic       en,
  input  logic       silence,
  output logic       siren,
  output logic       strobe,
  output logic [1:0] state,
  output logic [3:0] trip_cnt
);

  // state | meaning
  // IDLE  | waiting for a trip (armed alarm) or panic
  // DELAY | entry delay running, disarm cancels
  // SOUND | siren pulsing, duration counter running
  // HOLD  | siren timed out, strobe stays on until silenced
  typedef enum logic [1:0] {IDLE = 2'b00, DELAY = 2'b01, SOUND = 2'b10, HOLD = 2'b11} state_t;

  localparam logic [7:0] DLY_LAST  = 8'(DELAY_CYC - 1);
  localparam logic [7:0] DUR_LAST  = 8'(SIREN_CYC - 1);
  localparam logic [7:0] TONE_LAST = 8'(TONE_HALF - 1);

  state_t     cur, cur_nx;
  logic [7:0] dly_cnt, dly_nx;
  logic [7:0] dur_cnt, dur_nx;
  logic [7:0] tone_cnt, tone_nx;
  logic       tone_phase, phase_nx;
  logic       enter_sound;
  logic       sil_ok;

  assign sil_ok = silence & ~panic;

  always_comb begin
    cur_nx      = cur;
    dly_nx      = dly_cnt;
    dur_nx      = dur_cnt;
    tone_nx     = tone_cnt;
    phase_nx    = tone_phase;
    enter_sound = 1'b0;
    case (cur)
      IDLE: begin
        if (panic) enter_sound = 1'b1;
        else if (alarm && en) begin
          cur_nx = DELAY;
          dly_nx = 8'd0;
        end
      end
      DELAY: begin
        if (panic)                   enter_sound = 1'b1;
        else if (!en)                cur_nx = IDLE;
        else if (dly_cnt == DLY_LAST) enter_sound = 1'b1;
        else                         dly_nx = dly_cnt + 8'd1;
      end
      SOUND: begin
        if (sil_ok)                   cur_nx = IDLE;
        else if (dur_cnt == DUR_LAST) cur_nx = HOLD;
        else begin
          dur_nx = dur_cnt + 8'd1;
          // tone phase tracks floor(duration / TONE_HALF) parity without a divider
          if (tone_cnt == TONE_LAST) begin
            tone_nx  = 8'd0;
            phase_nx = ~tone_phase;
          end else begin
            tone_nx = tone_cnt + 8'd1;
          end
        end
      end
      HOLD: begin
        if (panic)        enter_sound = 1'b1;
        else if (silence) cur_nx = IDLE;
      end
      default: cur_nx = IDLE;
    endcase
    if (enter_sound) begin
      cur_nx   = SOUND;
      dur_nx   = 8'd0;
      tone_nx  = 8'd0;
      phase_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur        <= IDLE;
      dly_cnt    <= 8'd0;
      dur_cnt    <= 8'd0;
      tone_cnt   <= 8'd0;
      tone_phase <= 1'b0;
      siren      <= 1'b0;
      strobe     <= 1'b0;
      trip_cnt   <= 4'd0;
    end else begin
      cur        <= cur_nx;
      dly_cnt    <= dly_nx;
      dur_cnt    <= dur_nx;
      tone_cnt   <= tone_nx;
      tone_phase <= phase_nx;
      siren      <= (cur_nx == SOUND) && !phase_nx;
      strobe     <= (cur_nx == SOUND) || (cur_nx == HOLD);
      if (enter_sound && trip_cnt != 4'd15) trip_cnt <= trip_cnt + 4'd1;
    end
  end

  assign state = cur;

endmodule
